// File: rtl/uart_pkg.sv
// Shared types and constant helpers for the UART frame receive controller.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DONE
    } frm_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Inter-byte timeout in clock cycles; never allowed to collapse to zero.
    function automatic int to_cycles(input int clk_hz, input int bit_rate, input int bits);
        int cyc;
        cyc = (clk_hz / bit_rate) * bits;
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/uart_frm_buf.sv
// Payload buffer: single write port, registered read port with 1-cycle latency.
module uart_frm_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_reg;

    // The array carries no reset so it can map onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream into SYNC/LEN/payload/XOR-checksum packets and
// hands one validated payload at a time to the host.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         CLK_HZ       = 50000000,
    parameter int         BIT_RATE     = 115200,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_BITS = 20,
    localparam int        LW           = clog2(MAX_LEN + 1),
    localparam int        AW           = (clog2(MAX_LEN) > 1) ? clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    output logic          uart_rx_en,
    input  logic          uart_rx_valid,
    input  logic [7:0]    uart_rx_data,
    input  logic          uart_rx_break,
    output logic          frm_valid,
    output logic [LW-1:0] frm_len,
    input  logic          frm_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_break,
    output logic [7:0]    ovr_cnt
);

    localparam int            TO_CYC  = to_cycles(CLK_HZ, BIT_RATE, TIMEOUT_BITS);
    localparam int            TW      = clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    frm_state_t    state_reg, state_next;
    logic [LW-1:0] len_reg, len_next;
    logic [LW-1:0] idx_reg, idx_next;
    logic [7:0]    csum_reg, csum_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          frm_valid_reg, frm_valid_next;
    logic [LW-1:0] frm_len_reg, frm_len_next;
    logic [7:0]    ovr_cnt_reg, ovr_cnt_next;
    logic          err_csum_reg, err_csum_next;
    logic          err_len_reg, err_len_next;
    logic          err_timeout_reg, err_timeout_next;
    logic          err_break_reg, err_break_next;
    logic          uart_rx_en_reg;
    logic          wr_en;
    logic          active;
    logic          timeout_hit;

    assign active      = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                         (state_reg == ST_CSUM);
    assign timeout_hit = active && !uart_rx_valid && (to_cnt_reg == TO_LAST);

    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (!active || uart_rx_valid) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg != TO_LAST) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        len_next         = len_reg;
        idx_next         = idx_reg;
        csum_next        = csum_reg;
        frm_valid_next   = frm_valid_reg;
        frm_len_next     = frm_len_reg;
        ovr_cnt_next     = ovr_cnt_reg;
        err_csum_next    = 1'b0;
        err_len_next     = 1'b0;
        err_timeout_next = 1'b0;
        err_break_next   = 1'b0;
        wr_en            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enable && uart_rx_valid && (uart_rx_data == SYNC_BYTE)) begin
                    state_next = ST_LEN;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                // Abort priority: disable, then break (beats a same-cycle byte), then data, then timeout.
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (uart_rx_break) begin
                    state_next     = ST_IDLE;
                    err_break_next = 1'b1;
                end else if (uart_rx_valid) begin
                    if (state_reg == ST_LEN) begin
                        if (uart_rx_data == 8'h00) begin
                            len_next   = '0;
                            csum_next  = 8'h00;
                            state_next = ST_CSUM;
                        end else if (int'(uart_rx_data) > MAX_LEN) begin
                            err_len_next = 1'b1;
                            state_next   = ST_IDLE;
                        end else begin
                            len_next   = LW'(uart_rx_data);
                            idx_next   = '0;
                            csum_next  = uart_rx_data;
                            state_next = ST_PAYLOAD;
                        end
                    end else if (state_reg == ST_PAYLOAD) begin
                        wr_en     = 1'b1;
                        csum_next = csum_reg ^ uart_rx_data;
                        idx_next  = idx_reg + 1'b1;
                        if (idx_reg == len_reg - 1'b1) begin
                            state_next = ST_CSUM;
                        end
                    end else begin
                        if (uart_rx_data == csum_reg) begin
                            frm_valid_next = 1'b1;
                            frm_len_next   = len_reg;
                            state_next     = ST_DONE;
                        end else begin
                            err_csum_next = 1'b1;
                            state_next    = ST_IDLE;
                        end
                    end
                end else if (timeout_hit) begin
                    err_timeout_next = 1'b1;
                    state_next       = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (uart_rx_valid && (ovr_cnt_reg != 8'hFF)) begin
                    ovr_cnt_next = ovr_cnt_reg + 1'b1;
                end
                if (frm_ack) begin
                    frm_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            len_reg         <= '0;
            idx_reg         <= '0;
            csum_reg        <= 8'h00;
            to_cnt_reg      <= '0;
            frm_valid_reg   <= 1'b0;
            frm_len_reg     <= '0;
            ovr_cnt_reg     <= 8'h00;
            err_csum_reg    <= 1'b0;
            err_len_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_break_reg   <= 1'b0;
            uart_rx_en_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            idx_reg         <= idx_next;
            csum_reg        <= csum_next;
            to_cnt_reg      <= to_cnt_next;
            frm_valid_reg   <= frm_valid_next;
            frm_len_reg     <= frm_len_next;
            ovr_cnt_reg     <= ovr_cnt_next;
            err_csum_reg    <= err_csum_next;
            err_len_reg     <= err_len_next;
            err_timeout_reg <= err_timeout_next;
            err_break_reg   <= err_break_next;
            uart_rx_en_reg  <= enable;
        end
    end

    uart_frm_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (idx_reg[AW-1:0]),
        .wr_data (uart_rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign uart_rx_en  = uart_rx_en_reg;
    assign frm_valid   = frm_valid_reg;
    assign frm_len     = frm_len_reg;
    assign ovr_cnt     = ovr_cnt_reg;
    assign err_csum    = err_csum_reg;
    assign err_len     = err_len_reg;
    assign err_timeout = err_timeout_reg;
    assign err_break   = err_break_reg;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with hand-computed frames and checksums.
module tb_uart_rx_frame_ctrl;

    localparam int TO_CYC = 40;  // (1000/100)*4

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_break;
    logic       frm_valid;
    logic [4:0] frm_len;
    logic       frm_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_csum;
    logic       err_len;
    logic       err_timeout;
    logic       err_break;
    logic [7:0] ovr_cnt;

    int n_checks;
    int n_fail;
    int csum_seen;
    int len_seen;
    int to_seen;
    int brk_seen;

    uart_rx_frame_ctrl #(
        .CLK_HZ       (1000),
        .BIT_RATE     (100),
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .frm_valid     (frm_valid),
        .frm_len       (frm_len),
        .frm_ack       (frm_ack),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .err_csum      (err_csum),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_break     (err_break),
        .ovr_cnt       (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies; a pulse visible in one cycle is counted at the following edge.
    always @(posedge clk) begin
        if (err_csum)    csum_seen <= csum_seen + 1;
        if (err_len)     len_seen  <= len_seen + 1;
        if (err_timeout) to_seen   <= to_seen + 1;
        if (err_break)   brk_seen  <= brk_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check_eq(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic ack_frame(input string tag);
        @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
        check_eq(tag, {31'h0, frm_valid}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {frm_valid, frm_len, rd_data, err_csum, err_len, err_timeout,
                       err_break, ovr_cnt, uart_rx_en}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b0;
        int j;
        bit found;
        n_checks = 0; n_fail = 0;
        csum_seen = 0; len_seen = 0; to_seen = 0; brk_seen = 0;
        resetn = 1'b0; enable = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        uart_rx_break = 1'b0; frm_ack = 1'b0; rd_addr = 4'h0;

        wait_cycles(3);
        check_all_zero("reset_outputs");
        resetn = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_cycles(2);
        check_eq("rx_en_follows", {31'h0, uart_rx_en}, 32'h1);

        // Good frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        check_eq("good_valid", {31'h0, frm_valid}, 32'h1);
        check_eq("good_len", {27'h0, frm_len}, 32'h3);
        read_chk("good_rd0", 4'd0, 8'h11);
        read_chk("good_rd1", 4'd1, 8'h22);
        read_chk("good_rd2", 4'd2, 8'h33);
        ack_frame("good_ack");

        // Bad checksum, then a good single-byte frame
        c0 = csum_seen;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
        check_eq("bad_csum_pulse", {31'h0, err_csum}, 32'h1);
        wait_cycles(2);
        check_eq("bad_csum_count", csum_seen - c0, 32'h1);
        check_eq("bad_csum_novalid", {31'h0, frm_valid}, 32'h0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        check_eq("after_bad_valid", {31'h0, frm_valid}, 32'h1);
        check_eq("after_bad_len", {27'h0, frm_len}, 32'h1);
        read_chk("after_bad_rd0", 4'd0, 8'h5A);
        ack_frame("after_bad_ack");

        // Length error, then garbage before a good frame
        send_byte(8'hA5); send_byte(8'h11);
        check_eq("len_err_pulse", {31'h0, err_len}, 32'h1);
        wait_cycles(2);
        check_eq("len_err_count", len_seen, 32'h1);
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h13);
        check_eq("garbage_valid", {31'h0, frm_valid}, 32'h1);
        check_eq("garbage_len", {27'h0, frm_len}, 32'h2);
        read_chk("garbage_rd0", 4'd0, 8'hAA);
        read_chk("garbage_rd1", 4'd1, 8'hBB);
        ack_frame("garbage_ack");

        // Inter-byte timeout
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        found = 1'b0;
        j = 0;
        while (!found && j < TO_CYC + 10) begin
            @(negedge clk);
            j++;
            if (err_timeout) found = 1'b1;
        end
        check_eq("timeout_seen", {31'h0, found}, 32'h1);
        check_eq("timeout_latency_ok", {31'h0, (j >= TO_CYC - 1) && (j <= TO_CYC + 1)}, 32'h1);
        check_eq("timeout_novalid", {31'h0, frm_valid}, 32'h0);

        // Break mid-payload, remaining bytes must not form a frame
        b0 = brk_seen;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(negedge clk);
        uart_rx_break = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h22;
        @(negedge clk);
        uart_rx_break = 1'b0;
        uart_rx_valid = 1'b0;
        check_eq("break_pulse", {31'h0, err_break}, 32'h1);
        send_byte(8'h33); send_byte(8'h03);
        wait_cycles(2);
        check_eq("break_count", brk_seen - b0, 32'h1);
        check_eq("break_novalid", {31'h0, frm_valid}, 32'h0);

        // Overrun while a frame waits for ack
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
        check_eq("ovr_frame_valid", {31'h0, frm_valid}, 32'h1);
        check_eq("ovr_start", {24'h0, ovr_cnt}, 32'h0);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i));
            if (i == 9) check_eq("ovr_count10", {24'h0, ovr_cnt}, 32'd10);
        end
        check_eq("ovr_saturated", {24'h0, ovr_cnt}, 32'd255);
        check_eq("ovr_valid_held", {31'h0, frm_valid}, 32'h1);
        check_eq("ovr_len_held", {27'h0, frm_len}, 32'h2);
        read_chk("ovr_rd0", 4'd0, 8'hC3);
        read_chk("ovr_rd1", 4'd1, 8'h3C);
        @(negedge clk);
        frm_ack = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h77;
        @(negedge clk);
        frm_ack = 1'b0;
        uart_rx_valid = 1'b0;
        check_eq("ack_cycle_valid", {31'h0, frm_valid}, 32'h0);
        check_eq("ovr_no_wrap", {24'h0, ovr_cnt}, 32'd255);

        // Zero-length frame
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check_eq("zero_valid", {31'h0, frm_valid}, 32'h1);
        check_eq("zero_len", {27'h0, frm_len}, 32'h0);
        ack_frame("zero_ack");

        // Disable mid-frame: silent abort
        c0 = csum_seen + len_seen + to_seen + brk_seen;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_eq("disable_rx_en", {31'h0, uart_rx_en}, 32'h0);
        enable = 1'b1;
        wait_cycles(2);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        wait_cycles(2);
        check_eq("disable_novalid", {31'h0, frm_valid}, 32'h0);
        check_eq("disable_no_err", csum_seen + len_seen + to_seen + brk_seen - c0, 32'h0);

        // Reset mid-payload
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        wait_cycles(2);
        resetn = 1'b1;
        wait_cycles(2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        check_eq("post_reset_valid", {31'h0, frm_valid}, 32'h1);
        read_chk("post_reset_rd0", 4'd0, 8'h42);
        ack_frame("post_reset_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the UART receiver: drives its enable and consumes its byte stream (valid/data/break).
- Assembles bytes into framed packets: SYNC, LEN, LEN payload bytes, XOR checksum.
- Buffers one validated payload, presents it to the host with a valid/ack handshake, and reports framing errors.
- Sits between UART_RX and the command decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 115200, UART bit rate. Must match the UART_RX instance.
- MAX_LEN, 16, maximum payload bytes (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods. TO_CYC = (CLK_HZ/BIT_RATE)*TIMEOUT_BITS.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  controller enable.
- uart_rx_en  out  1  receive enable to UART_RX.
- uart_rx_valid  in  1  one-cycle pulse, byte available.
- uart_rx_data  in  8  received byte.
- uart_rx_break  in  1  break detected.
- frm_valid  out  1  buffered frame ready.
- frm_len  out  LW  payload length, LW = clog2(MAX_LEN+1).
- frm_ack  in  1  pulse, host done with frame.
- rd_addr  in  AW  payload read index, AW = max(1, clog2(MAX_LEN)).
- rd_data  out  8  payload byte; registered, 1-cycle read latency.
- err_csum, err_len, err_timeout, err_break  out  1 each  one-cycle error pulses.
- ovr_cnt  out  8  dropped-byte count, saturating at 255.

Behaviour:
- Reset clears every output to 0: uart_rx_en, frm_valid, frm_len, rd_data, all err_*, ovr_cnt. The FSM goes to IDLE.
- uart_rx_en is a register equal to enable, delayed by one cycle.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, DONE.
- IDLE: on a valid byte equal to SYNC_BYTE, go to LEN. Any other byte is silently discarded.
- LEN:
  - L = 0 → go to CSUM.
  - L > MAX_LEN → pulse err_len, go to IDLE.
  - Otherwise store L, clear the byte index, set csum_acc = L, go to PAYLOAD.
- PAYLOAD: each valid byte is written to buf[idx], XORed into csum_acc, and idx increments. After byte L-1, go to CSUM.
- CSUM:
  - Byte == csum_acc → frm_len = L, frm_valid = 1 in the next cycle, go to DONE.
  - Otherwise pulse err_csum and go to IDLE. The buffer is not presented.
- DONE:
  - frm_valid is held until frm_ack; the buffer contents are stable.
  - Valid bytes arriving in DONE are dropped and ovr_cnt increments.
  - On frm_ack: frm_valid drops in the next cycle, go to IDLE.
  - A byte arriving in the ack cycle is dropped and counted.
  - frm_ack outside DONE is ignored.
- Timeout:
  - Counter reloads on every valid byte and is active only in LEN, PAYLOAD and CSUM.
  - On reaching TO_CYC: pulse err_timeout, go to IDLE.
- Break: in LEN, PAYLOAD or CSUM, uart_rx_break aborts to IDLE and pulses err_break. Break is ignored in IDLE and DONE.
- Simultaneous break and valid byte in the same cycle: break wins and the byte is discarded.
- enable = 0: LEN, PAYLOAD and CSUM abort to IDLE with no error pulse. DONE is held until acked.
- Read port: rd_data = buf[rd_addr] registered every cycle. Addresses ≥ frm_len return stale data (don't-care).
- ovr_cnt never wraps.
- Reset mid-frame discards all partial state.

Decomposition:
- uart_pkg holds:
  - FSM state enum;
  - default SYNC_BYTE;
  - clog2 function;
  - TO_CYC computation as a constant function.
- One sub-module, uart_frm_buf: MAX_LEN x 8 register file with a single write port and a registered read port.
- The FSM, timeout counter and checksum stay in the top module.

Test Plan:
- Good frame A5 03 11 22 33 03 → frm_valid=1, frm_len=3. rd_addr 0/1/2 → rd_data 11/22/33 after 1 cycle. frm_ack → frm_valid=0 next cycle.
- Bad checksum A5 03 11 22 33 04 → err_csum pulse, frm_valid stays 0. A following good frame is accepted.
- Length error A5 11 with MAX_LEN=16 → err_len pulse, FSM in IDLE. Garbage bytes 00 FF before A5 02 AA BB 13 → frame accepted with len 2.
- Timeout: A5 02 AA, then idle for more than TO_CYC → err_timeout. Break asserted mid-payload → err_break. Neither case raises frm_valid.
- Overrun: frame held without ack while 300 bytes are sent → ovr_cnt=255, buffer data unchanged, frm_valid held.
- Reset and enable: resetn low mid-payload → all outputs 0. enable=0 mid-frame → IDLE, uart_rx_en=0 one cycle later. Zero-length frame A5 00 00 → frm_valid with len 0.
